// File: rtl/cpu_pkg.sv
// Shared CPU types: write-back data select, load size and write-back FSM state.
package cpu_pkg;

    typedef enum logic [1:0] {
        WB_PC  = 2'b00,
        WB_PC1 = 2'b01,
        WB_MEM = 2'b10,
        WB_EXE = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_e;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/write_back_pipe_load_align.sv
// Load data alignment: picks the byte/half lane from an aligned word and
// zero- or sign-extends it to the datapath width.
module load_align
    import cpu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] i_rdata,
    input  logic [1:0]   i_size,
    input  logic         i_signed,
    input  logic [1:0]   i_offs,
    output logic [N-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        unique case (i_offs)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        // Half loads ignore offs[0]; the lane is picked by offs[1] alone.
        w_half = i_offs[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_data = i_rdata;
        unique case (i_size)
            SZ_B:    o_data = {{(N-8){i_signed & w_byte[7]}}, w_byte};
            SZ_H:    o_data = {{(N-16){i_signed & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/write_back_pipe.sv
// MEM/WB register, result select and register-file write port with
// late-load wait state, WB->decode bypass and retire/stall counters.
module write_back_pipe
    import cpu_pkg::*;
#(
    parameter int N        = 32,
    parameter int RA_W     = 5,
    parameter int LR_IDX   = 31,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [N-1:0]     exe_out,
    input  logic [N-1:0]     pc_inc4,
    input  logic [RA_W-1:0]  rx,
    input  logic [1:0]       wb_data_sel,
    input  logic             wb_reg_sel,
    input  logic [1:0]       mem_size,
    input  logic             mem_signed,
    input  logic [1:0]       mem_offs,
    input  logic             mem_rvalid,
    input  logic [N-1:0]     mem_rdata,
    output logic             rf_we,
    output logic [RA_W-1:0]  rf_waddr,
    output logic [N-1:0]     rf_wdata,
    output logic             fwd_valid,
    output logic [RA_W-1:0]  fwd_reg,
    output logic [N-1:0]     fwd_data,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    wb_state_e        r_state;
    logic [RA_W-1:0]  r_waddr;
    logic [1:0]       r_size;
    logic             r_signed;
    logic [1:0]       r_offs;
    logic             r_rf_we;
    logic [RA_W-1:0]  r_rf_waddr;
    logic [N-1:0]     r_rf_wdata;
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] r_stall;

    logic             w_idle;
    logic             w_accept;
    logic             w_is_load;
    logic             w_commit_now;
    logic             w_go_wait;
    logic             w_commit_wait;
    logic             w_commit;
    logic [RA_W-1:0]  w_waddr;
    logic [RA_W-1:0]  w_cwaddr;
    logic [1:0]       w_size;
    logic             w_signed;
    logic [1:0]       w_offs;
    logic [N-1:0]     w_ldata;
    logic [N-1:0]     w_sel_data;
    logic [N-1:0]     w_cdata;

    assign w_idle        = (r_state == WB_IDLE);
    assign in_ready      = w_idle;
    assign w_accept      = w_idle & in_valid & ~flush;
    assign w_is_load     = (wb_data_sel == WB_MEM);
    assign w_commit_now  = w_accept & (~w_is_load | mem_rvalid);
    assign w_go_wait     = w_accept & w_is_load & ~mem_rvalid;
    assign w_commit_wait = ~w_idle & mem_rvalid;
    assign w_commit      = w_commit_now | w_commit_wait;
    assign w_waddr       = wb_reg_sel ? rx : RA_W'(LR_IDX);

    // While waiting, the aligner works from the captured load control.
    assign w_size   = w_idle ? mem_size   : r_size;
    assign w_signed = w_idle ? mem_signed : r_signed;
    assign w_offs   = w_idle ? mem_offs   : r_offs;

    load_align #(.N(N)) u_align (
        .i_rdata  (mem_rdata),
        .i_size   (w_size),
        .i_signed (w_signed),
        .i_offs   (w_offs),
        .o_data   (w_ldata)
    );

    always_comb begin
        w_sel_data = pc_inc4;
        unique case (wb_data_sel)
            WB_MEM:  w_sel_data = w_ldata;
            WB_EXE:  w_sel_data = exe_out;
            default: w_sel_data = pc_inc4;
        endcase
    end

    assign w_cwaddr = w_commit_wait ? r_waddr : w_waddr;
    assign w_cdata  = w_commit_wait ? w_ldata : w_sel_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= WB_IDLE;
            r_waddr    <= '0;
            r_size     <= '0;
            r_signed   <= 1'b0;
            r_offs     <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_retired  <= '0;
            r_stall    <= '0;
        end else begin
            r_rf_we <= 1'b0;
            if (w_commit) begin
                r_rf_we    <= !((ZERO_REG != 0) && (w_cwaddr == '0));
                r_rf_waddr <= w_cwaddr;
                r_rf_wdata <= w_cdata;
                r_retired  <= r_retired + CNT_W'(1);
            end
            if (!w_idle) begin
                r_stall <= r_stall + CNT_W'(1);
            end
            unique case (r_state)
                WB_IDLE: begin
                    if (w_go_wait) begin
                        r_state  <= WB_WAIT_MEM;
                        r_waddr  <= w_waddr;
                        r_size   <= mem_size;
                        r_signed <= mem_signed;
                        r_offs   <= mem_offs;
                    end
                end
                WB_WAIT_MEM: begin
                    if (mem_rvalid) begin
                        r_state <= WB_IDLE;
                    end
                end
                default: r_state <= WB_IDLE;
            endcase
        end
    end

    assign rf_we       = r_rf_we;
    assign rf_waddr    = r_rf_waddr;
    assign rf_wdata    = r_rf_wdata;
    assign fwd_valid   = r_rf_we;
    assign fwd_reg     = r_rf_waddr;
    assign fwd_data    = r_rf_wdata;
    assign retired_cnt = r_retired;
    assign stall_cnt   = r_stall;

endmodule

// File: tb/tb_write_back_pipe.sv
// Self-checking bench for write_back_pipe: directed scenarios plus
// randomized transactions against a behavioural reference model.
module tb_write_back_pipe;

    localparam int N     = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [N-1:0]     exe_out;
    logic [N-1:0]     pc_inc4;
    logic [RA_W-1:0]  rx;
    logic [1:0]       wb_data_sel;
    logic             wb_reg_sel;
    logic [1:0]       mem_size;
    logic             mem_signed;
    logic [1:0]       mem_offs;
    logic             mem_rvalid;
    logic [N-1:0]     mem_rdata;
    logic             rf_we;
    logic [RA_W-1:0]  rf_waddr;
    logic [N-1:0]     rf_wdata;
    logic             fwd_valid;
    logic [RA_W-1:0]  fwd_reg;
    logic [N-1:0]     fwd_data;
    logic [CNT_W-1:0] retired_cnt;
    logic [CNT_W-1:0] stall_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned exp_ret  = 0;
    int unsigned exp_stall = 0;

    write_back_pipe #(
        .N(N), .RA_W(RA_W), .LR_IDX(31), .ZERO_REG(1), .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .exe_out     (exe_out),
        .pc_inc4     (pc_inc4),
        .rx          (rx),
        .wb_data_sel (wb_data_sel),
        .wb_reg_sel  (wb_reg_sel),
        .mem_size    (mem_size),
        .mem_signed  (mem_signed),
        .mem_offs    (mem_offs),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .fwd_valid   (fwd_valid),
        .fwd_reg     (fwd_reg),
        .fwd_data    (fwd_data),
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] sz,
                                             input logic sg, input logic [1:0] of);
        int unsigned v;
        if (sz == 2'd0) begin
            v = (d >> (8 * int'(of))) & 32'hFF;
            if (sg && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (d >> (16 * (int'(of) / 2))) & 32'hFFFF;
            if (sg && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_data(input logic [1:0] sel, input logic [31:0] exe,
                                             input logic [31:0] pc, input logic [31:0] ld);
        if (sel == 2'd3) return exe;
        if (sel == 2'd2) return ld;
        return pc;
    endfunction

    function automatic logic [4:0] ref_addr(input logic rs, input logic [4:0] r);
        return rs ? r : 5'd31;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        flush       = 1'b0;
        exe_out     = '0;
        pc_inc4     = '0;
        rx          = '0;
        wb_data_sel = 2'b00;
        wb_reg_sel  = 1'b0;
        mem_size    = 2'b00;
        mem_signed  = 1'b0;
        mem_offs    = 2'b00;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [31:0] exe, input logic [31:0] pc,
                         input logic [4:0] r, input logic rs, input logic [1:0] sz,
                         input logic sg, input logic [1:0] of);
        in_valid    = 1'b1;
        wb_data_sel = sel;
        exe_out     = exe;
        pc_inc4     = pc;
        rx          = r;
        wb_reg_sel  = rs;
        mem_size    = sz;
        mem_signed  = sg;
        mem_offs    = of;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_wb: we/addr/data=%b/%0d/%h required 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        n_checks++;
        if (retired_cnt !== 0 || stall_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_cnt: retired=%0d stall=%0d required 0/0", retired_cnt, stall_cnt);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        drive(2'b11, 32'hDEAD_BEEF, 32'h0, 5'd5, 1'b1, 2'b10, 1'b0, 2'b00);
        tick();
        idle_inputs();
        exp_ret++;
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL alu: we/addr/data=%b/%0d/%h required 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        n_checks++;
        if ({fwd_valid, fwd_reg, fwd_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL alu_fwd: v/reg/data=%b/%0d/%h required 1/5/deadbeef", fwd_valid, fwd_reg, fwd_data);
        end
        n_checks++;
        if (retired_cnt !== exp_ret) begin
            n_fail++;
            $display("FAIL alu_retired: retired=%0d required %0d", retired_cnt, exp_ret);
        end
        tick();
        n_checks++;
        if (rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_we_pulse: rf_we=%b required 0", rf_we);
        end
    endtask

    task automatic test_link();
        drive(2'b00, 32'h5555_5555, 32'h104, 5'd7, 1'b0, 2'b10, 1'b0, 2'b00);
        tick();
        idle_inputs();
        exp_ret++;
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd31, 32'h104}) begin
            n_fail++;
            $display("FAIL link: we/addr/data=%b/%0d/%h required 1/31/104", rf_we, rf_waddr, rf_wdata);
        end
        tick();
    endtask

    task automatic test_delayed_load();
        drive(2'b10, 32'h0, 32'h0, 5'd9, 1'b1, 2'b00, 1'b1, 2'b10);
        mem_rvalid = 1'b0;
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (in_ready !== 1'b0 || rf_we !== 1'b0) begin
                n_fail++;
                $display("FAIL dload_wait%0d: in_ready=%b rf_we=%b required 0/0", k, in_ready, rf_we);
            end
            mem_rvalid = (k == 2);
            mem_rdata  = (k == 2) ? 32'h0080_0000 : 32'hFFFF_FFFF;
            tick();
        end
        idle_inputs();
        exp_ret++;
        exp_stall += 3;
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'hFFFF_FF80}) begin
            n_fail++;
            $display("FAIL dload: we/addr/data=%b/%0d/%h required 1/9/ffffff80", rf_we, rf_waddr, rf_wdata);
        end
        n_checks++;
        if (stall_cnt !== exp_stall || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL dload_stall: stall=%0d ready=%b required %0d/1", stall_cnt, in_ready, exp_stall);
        end
    endtask

    task automatic test_half_same_cycle();
        drive(2'b10, 32'h0, 32'h0, 5'd12, 1'b1, 2'b01, 1'b0, 2'b10);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h8001_1234;
        tick();
        idle_inputs();
        exp_ret++;
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd12, 32'h0000_8001}) begin
            n_fail++;
            $display("FAIL half: we/addr/data=%b/%0d/%h required 1/12/00008001", rf_we, rf_waddr, rf_wdata);
        end
        n_checks++;
        if (in_ready !== 1'b1 || stall_cnt !== exp_stall) begin
            n_fail++;
            $display("FAIL half_nostall: ready=%b stall=%0d required 1/%0d", in_ready, stall_cnt, exp_stall);
        end
        tick();
    endtask

    task automatic test_flush_idle();
        drive(2'b11, 32'h1111_2222, 32'h0, 5'd3, 1'b1, 2'b10, 1'b0, 2'b00);
        flush = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (rf_we !== 1'b0 || retired_cnt !== exp_ret || stall_cnt !== exp_stall) begin
            n_fail++;
            $display("FAIL flush_idle: we=%b retired=%0d stall=%0d required 0/%0d/%0d",
                     rf_we, retired_cnt, stall_cnt, exp_ret, exp_stall);
        end
    endtask

    task automatic test_flush_wait();
        drive(2'b10, 32'h0, 32'h0, 5'd14, 1'b1, 2'b10, 1'b0, 2'b00);
        tick();
        drive(2'b11, 32'hABCD_0000, 32'h0, 5'd20, 1'b1, 2'b00, 1'b1, 2'b11);
        flush = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        idle_inputs();
        exp_ret++;
        exp_stall += 2;
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd14, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL flush_wait: we/addr/data=%b/%0d/%h required 1/14/12345678", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        n_checks++;
        if (rf_we !== 1'b0 || retired_cnt !== exp_ret) begin
            n_fail++;
            $display("FAIL flush_wait_once: we=%b retired=%0d required 0/%0d", rf_we, retired_cnt, exp_ret);
        end
    endtask

    task automatic test_zero_reg();
        drive(2'b11, 32'hCAFE_F00D, 32'h0, 5'd0, 1'b1, 2'b10, 1'b0, 2'b00);
        tick();
        idle_inputs();
        exp_ret++;
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'hCAFE_F00D} || retired_cnt !== exp_ret) begin
            n_fail++;
            $display("FAIL zero_reg: we/addr/data=%b/%0d/%h retired=%0d required 0/0/cafef00d/%0d",
                     rf_we, rf_waddr, rf_wdata, retired_cnt, exp_ret);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int k = 0; k < 4; k++) begin
            d = $urandom;
            drive(2'b11, d, 32'h0, 5'(k + 1), 1'b1, 2'b10, 1'b0, 2'b00);
            tick();
            exp_ret++;
            n_checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(k + 1), d}) begin
                n_fail++;
                $display("FAIL b2b%0d: we/addr/data=%b/%0d/%h required 1/%0d/%h",
                         k, rf_we, rf_waddr, rf_wdata, k + 1, d);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [1:0]  sel, sz, of;
        logic        sg, rs, fl, now;
        logic [4:0]  r, ea;
        logic [31:0] exe, pc, d, ed;
        int          delay;
        for (int t = 0; t < 150; t++) begin
            sel = 2'($urandom);
            sz  = 2'($urandom);
            of  = 2'($urandom);
            sg  = 1'($urandom);
            rs  = 1'($urandom);
            r   = 5'($urandom);
            exe = $urandom;
            pc  = $urandom;
            d   = $urandom;
            fl  = ($urandom_range(0, 7) == 0);
            now = 1'($urandom);
            drive(sel, exe, pc, r, rs, sz, sg, of);
            flush      = fl;
            mem_rvalid = now;
            mem_rdata  = d;
            if ($urandom_range(0, 5) == 0) in_valid = 1'b0;
            ea = ref_addr(rs, r);
            tick();
            if (!in_valid || fl) begin
                idle_inputs();
                n_checks++;
                if (rf_we !== 1'b0 || in_ready !== 1'b1 || retired_cnt !== exp_ret) begin
                    n_fail++;
                    $display("FAIL rnd_nop%0d: we=%b ready=%b retired=%0d required 0/1/%0d",
                             t, rf_we, in_ready, retired_cnt, exp_ret);
                end
                continue;
            end
            if (sel == 2'b10 && !now) begin
                delay = $urandom_range(1, 4);
                for (int k = 0; k < delay; k++) begin
                    n_checks++;
                    if (in_ready !== 1'b0 || rf_we !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rnd_wait%0d: ready=%b we=%b required 0/0", t, in_ready, rf_we);
                    end
                    drive(2'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom),
                          2'($urandom), 1'($urandom), 2'($urandom));
                    flush      = 1'($urandom);
                    mem_rvalid = (k == delay - 1);
                    mem_rdata  = $urandom;
                    if (k == delay - 1) d = mem_rdata;
                    tick();
                end
                exp_stall += delay;
            end
            idle_inputs();
            exp_ret++;
            ed = ref_data(sel, exe, pc, ref_load(d, sz, sg, of));
            n_checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {(ea != 5'd0), ea, ed}) begin
                n_fail++;
                $display("FAIL rnd_commit%0d: we/addr/data=%b/%0d/%h required %b/%0d/%h",
                         t, rf_we, rf_waddr, rf_wdata, (ea != 5'd0), ea, ed);
            end
            if ($urandom_range(0, 3) == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom;
                tick();
                idle_inputs();
                n_checks++;
                if (rf_we !== 1'b0 || in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rnd_stray_rvalid%0d: we=%b ready=%b required 0/1", t, rf_we, in_ready);
                end
            end
        end
        n_checks++;
        if (retired_cnt !== exp_ret || stall_cnt !== exp_stall) begin
            n_fail++;
            $display("FAIL rnd_counters: retired=%0d stall=%0d required %0d/%0d",
                     retired_cnt, stall_cnt, exp_ret, exp_stall);
        end
    endtask

    task automatic test_reset_wait();
        drive(2'b10, 32'h0, 32'h0, 5'd8, 1'b1, 2'b10, 1'b0, 2'b00);
        tick();
        idle_inputs();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata, retired_cnt, stall_cnt} !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wait: we/addr/data=%b/%0d/%h retired=%0d stall=%0d ready=%b required all 0, ready 1",
                     rf_we, rf_waddr, rf_wdata, retired_cnt, stall_cnt, in_ready);
        end
        tick();
        rst_n = 1'b1;
        exp_ret   = 0;
        exp_stall = 0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        tick();
        idle_inputs();
        n_checks++;
        if (rf_we !== 1'b0 || retired_cnt !== 0 || stall_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_drop: we=%b retired=%0d stall=%0d required 0/0/0",
                     rf_we, retired_cnt, stall_cnt);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        #3;
        test_reset();
        test_alu();
        test_link();
        test_delayed_load();
        test_half_same_cycle();
        test_flush_idle();
        test_flush_wait();
        test_zero_reg();
        test_back_to_back();
        test_random();
        test_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
